// File: rtl/simt_reconv_stack.sv
// Per-warp SIMT reconvergence stacks: one request at a time walks IDLE -> EXEC -> POPCHK -> RESP,
// applying a control-flow operation to the addressed warp's stack and reporting the new top of stack.
module simt_reconv_stack #(
    parameter int                WARPS    = 32,
    parameter int                DEPTH    = 8,
    parameter int                LANES    = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [$clog2(WARPS)-1:0]   s_warp,
    input  logic [2:0]                 s_op,
    input  logic [ADDR_W-1:0]          s_addr,
    input  logic [LANES-1:0]           s_pred,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(WARPS)-1:0]   m_warp,
    output logic [ADDR_W-1:0]          m_npc,
    output logic [LANES-1:0]           m_mask,
    output logic [3:0]                 m_err,
    output logic [WARPS*ADDR_W-1:0]    tos_npc,
    output logic [WARPS*LANES-1:0]     tos_mask
);
    localparam int WW = $clog2(WARPS);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_PC4    = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_PUSH   = 3'd4;
    localparam logic [2:0] OP_POP    = 3'd5;
    localparam logic [2:0] OP_FLUSH  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_POPCHK, S_RESP} state_t;

    state_t state_q, state_d;

    logic [WW-1:0]     req_warp_q;
    logic [2:0]        req_op_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [LANES-1:0]  req_pred_q;
    logic [3:0]        err_q;

    logic [ADDR_W-1:0] rpc_q  [WARPS][DEPTH];
    logic [ADDR_W-1:0] npc_q  [WARPS][DEPTH];
    logic [LANES-1:0]  mask_q [WARPS][DEPTH];
    logic [CW-1:0]     cnt_q  [WARPS];

    logic [ADDR_W-1:0] tos_npc_q;
    logic [LANES-1:0]  tos_mask_q;
    logic [WARPS*ADDR_W-1:0] tos_npc_r;
    logic [WARPS*LANES-1:0]  tos_mask_r;

    function automatic logic [ADDR_W-1:0] sext16(input logic [15:0] v);
        return {{(ADDR_W-16){v[15]}}, v};
    endfunction

    // Current top-of-stack view of the warp being served.
    logic [CW-1:0]     cur_cnt;
    logic [IW-1:0]     cur_top;
    logic [ADDR_W-1:0] cur_rpc, cur_npc;
    logic [LANES-1:0]  cur_mask;
    logic              need_pop;

    assign cur_cnt  = cnt_q[req_warp_q];
    assign cur_top  = IW'(cur_cnt - CW'(1));
    assign cur_rpc  = rpc_q[req_warp_q][cur_top];
    assign cur_npc  = npc_q[req_warp_q][cur_top];
    assign cur_mask = mask_q[req_warp_q][cur_top];
    assign need_pop = (cur_cnt > CW'(1)) && (cur_rpc == cur_npc);
    assign tos_npc_q  = cur_npc;
    assign tos_mask_q = cur_mask;

    // Operation decode for the EXEC cycle.
    logic [CW-1:0]     ex_cnt;
    logic              ex_npc_we, ex_push_a, ex_push_b, ex_flush;
    logic [ADDR_W-1:0] ex_npc_val, ex_rpc_new, ex_tgt, ex_npc4;
    logic [LANES-1:0]  ex_taken, ex_a_mask;
    logic [3:0]        ex_err;
    logic [IW-1:0]     ex_a_idx, ex_b_idx;

    assign ex_rpc_new = cur_npc + sext16(req_addr_q[31:16]);
    assign ex_tgt     = cur_npc + sext16(req_addr_q[15:0]);
    assign ex_npc4    = cur_npc + ADDR_W'(4);
    assign ex_taken   = req_pred_q & cur_mask;
    assign ex_a_idx   = IW'(cur_cnt);
    assign ex_b_idx   = IW'(cur_cnt + CW'(1));

    always_comb begin
        ex_cnt     = cur_cnt;
        ex_npc_we  = 1'b0;
        ex_npc_val = cur_npc;
        ex_push_a  = 1'b0;
        ex_push_b  = 1'b0;
        ex_a_mask  = cur_mask & ~ex_taken;
        ex_flush   = 1'b0;
        ex_err     = 4'b0000;
        case (req_op_q)
            OP_PC4: begin
                ex_npc_we  = 1'b1;
                ex_npc_val = ex_npc4;
            end
            OP_JUMP: begin
                ex_npc_we  = 1'b1;
                ex_npc_val = req_addr_q;
            end
            OP_BRANCH: begin
                ex_err[2] = |(req_pred_q & ~cur_mask);
                if (ex_taken == '0) begin
                    ex_npc_we  = 1'b1;
                    ex_npc_val = ex_npc4;
                end else if (ex_taken == cur_mask) begin
                    ex_npc_we  = 1'b1;
                    ex_npc_val = ex_tgt;
                end else if (cur_cnt <= CW'(DEPTH - 2)) begin
                    // Not-taken path sits below the taken path, both reconverging at rpc.
                    ex_npc_we  = 1'b1;
                    ex_npc_val = ex_rpc_new;
                    ex_push_a  = 1'b1;
                    ex_push_b  = 1'b1;
                    ex_cnt     = cur_cnt + CW'(2);
                end else begin
                    ex_err[1] = 1'b1;
                end
            end
            OP_PUSH: begin
                if (cur_cnt < CW'(DEPTH)) begin
                    ex_push_a = 1'b1;
                    ex_a_mask = ex_taken;
                    ex_cnt    = cur_cnt + CW'(1);
                end else begin
                    ex_err[1] = 1'b1;
                end
            end
            OP_POP: begin
                if (cur_cnt > CW'(1)) ex_cnt = cur_cnt - CW'(1);
                else                  ex_err[0] = 1'b1;
            end
            OP_FLUSH: begin
                ex_flush = 1'b1;
                ex_cnt   = CW'(1);
            end
            default: ex_err[3] = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (s_valid) state_d = S_EXEC;
            S_EXEC:   state_d = S_POPCHK;
            S_POPCHK: if (!need_pop) state_d = m_ready ? S_IDLE : S_RESP;
            S_RESP:   if (m_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs: the response is presented as soon as no further reconvergence pop is due.
    always_comb begin
        s_ready = (state_q == S_IDLE);
        m_valid = ((state_q == S_POPCHK) && !need_pop) || (state_q == S_RESP);
    end

    assign m_warp   = req_warp_q;
    assign m_npc    = m_valid ? cur_npc  : '0;
    assign m_mask   = m_valid ? cur_mask : '0;
    assign m_err    = m_valid ? err_q    : 4'b0000;
    assign tos_npc  = tos_npc_r;
    assign tos_mask = tos_mask_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_warp_q <= '0;
            req_op_q   <= 3'd0;
            req_addr_q <= '0;
            req_pred_q <= '0;
            err_q      <= 4'b0000;
        end else begin
            if (state_q == S_IDLE && s_valid) begin
                req_warp_q <= s_warp;
                req_op_q   <= s_op;
                req_addr_q <= s_addr;
                req_pred_q <= s_pred;
            end
            if (state_q == S_EXEC) err_q <= ex_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WARPS; w++) begin
                cnt_q[w] <= CW'(1);
                for (int d = 0; d < DEPTH; d++) begin
                    rpc_q[w][d]  <= '1;
                    npc_q[w][d]  <= RESET_PC;
                    mask_q[w][d] <= '1;
                end
            end
        end else if (state_q == S_EXEC) begin
            if (ex_npc_we) npc_q[req_warp_q][cur_top] <= ex_npc_val;
            if (ex_push_a) begin
                rpc_q[req_warp_q][ex_a_idx]  <= ex_rpc_new;
                npc_q[req_warp_q][ex_a_idx]  <= ex_npc4;
                mask_q[req_warp_q][ex_a_idx] <= ex_a_mask;
            end
            if (ex_push_b) begin
                rpc_q[req_warp_q][ex_b_idx]  <= ex_rpc_new;
                npc_q[req_warp_q][ex_b_idx]  <= ex_tgt;
                mask_q[req_warp_q][ex_b_idx] <= ex_taken;
            end
            if (ex_flush) begin
                npc_q[req_warp_q][0]  <= req_addr_q;
                mask_q[req_warp_q][0] <= '1;
            end
            cnt_q[req_warp_q] <= ex_cnt;
        end else if (state_q == S_POPCHK && need_pop) begin
            cnt_q[req_warp_q] <= cur_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WARPS; w++) begin
                tos_npc_r[w*ADDR_W +: ADDR_W] <= RESET_PC;
                tos_mask_r[w*LANES +: LANES]  <= '1;
            end
        end else if (m_valid && m_ready) begin
            tos_npc_r[int'(req_warp_q)*ADDR_W +: ADDR_W] <= tos_npc_q;
            tos_mask_r[int'(req_warp_q)*LANES +: LANES]  <= tos_mask_q;
        end
    end

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Bench for simt_reconv_stack: queue-based stack model per warp, scoreboard of expected responses,
// randomized operations plus directed divergence, overflow, back-pressure and mid-operation reset cases.
module tb_simt_reconv_stack;
    localparam int NW = 4;
    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid, s_ready;
    logic [1:0]    s_warp;
    logic [2:0]    s_op;
    logic [31:0]   s_addr, s_pred;
    logic          m_valid, m_ready;
    logic [1:0]    m_warp;
    logic [31:0]   m_npc, m_mask;
    logic [3:0]    m_err;
    logic [NW*32-1:0] tos_npc, tos_mask;

    simt_reconv_stack #(.WARPS(NW), .DEPTH(ND), .LANES(32), .ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_warp(s_warp), .s_op(s_op),
        .s_addr(s_addr), .s_pred(s_pred),
        .m_valid(m_valid), .m_ready(m_ready), .m_warp(m_warp), .m_npc(m_npc),
        .m_mask(m_mask), .m_err(m_err), .tos_npc(tos_npc), .tos_mask(tos_mask)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] rpc;
        logic [31:0] npc;
        logic [31:0] mask;
    } ent_t;

    typedef struct packed {
        logic [1:0]  warp;
        logic [31:0] npc;
        logic [31:0] mask;
        logic [3:0]  err;
        logic [7:0]  lat;
        logic [31:0] acc;
    } exp_t;

    ent_t stk [NW][$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic hold_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each warp is a queue whose back is the top of stack.
    function automatic void model_reset();
        ent_t b;
        b.rpc = 32'hFFFF_FFFF; b.npc = 32'h0; b.mask = 32'hFFFF_FFFF;
        for (int w = 0; w < NW; w++) begin
            stk[w].delete();
            stk[w].push_back(b);
        end
    endfunction

    function automatic ent_t model_top(input int w);
        return stk[w][stk[w].size()-1];
    endfunction

    function automatic exp_t model_op(input int w, input logic [2:0] op, input logic [31:0] addr,
                                      input logic [31:0] pred);
        exp_t e;
        ent_t top, na, nb;
        logic [31:0] hi, lo, m, t;
        int   pops = 0;
        e = '0;
        top = model_top(w);
        hi = {{16{addr[31]}}, addr[31:16]};
        lo = {{16{addr[15]}}, addr[15:0]};
        m = top.mask;
        t = pred & m;
        case (op)
            3'd1: begin top.npc = top.npc + 4; stk[w][stk[w].size()-1] = top; end
            3'd2: begin top.npc = addr;        stk[w][stk[w].size()-1] = top; end
            3'd3: begin
                if ((pred & ~m) != 0) e.err[2] = 1'b1;
                if (t == 0) begin
                    top.npc = top.npc + 4; stk[w][stk[w].size()-1] = top;
                end else if (t == m) begin
                    top.npc = top.npc + lo; stk[w][stk[w].size()-1] = top;
                end else if (stk[w].size() + 2 <= ND) begin
                    na.rpc = top.npc + hi; na.npc = top.npc + 4;  na.mask = m & ~t;
                    nb.rpc = top.npc + hi; nb.npc = top.npc + lo; nb.mask = t;
                    top.npc = na.rpc; stk[w][stk[w].size()-1] = top;
                    stk[w].push_back(na);
                    stk[w].push_back(nb);
                end else e.err[1] = 1'b1;
            end
            3'd4: begin
                if (stk[w].size() < ND) begin
                    na.rpc = top.npc + hi; na.npc = top.npc + 4; na.mask = t;
                    stk[w].push_back(na);
                end else e.err[1] = 1'b1;
            end
            3'd5: begin
                if (stk[w].size() > 1) void'(stk[w].pop_back());
                else e.err[0] = 1'b1;
            end
            3'd6: begin
                na.rpc = 32'hFFFF_FFFF; na.npc = addr; na.mask = 32'hFFFF_FFFF;
                stk[w].delete();
                stk[w].push_back(na);
            end
            default: e.err[3] = 1'b1;
        endcase
        while (stk[w].size() > 1 && model_top(w).npc == model_top(w).rpc) begin
            void'(stk[w].pop_back());
            pops++;
        end
        e.warp = 2'(w);
        e.npc  = model_top(w).npc;
        e.mask = model_top(w).mask;
        e.lat  = 8'(2 + pops);
        return e;
    endfunction

    // Driver: present one request at a negedge once the unit is ready.
    task automatic do_op(input int w, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] pred, input bit expect_resp);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        while (!s_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            total++; bad++;
            $display("FAIL s_ready_timeout: got 0 expected 1 after %0d cycles", waited);
            return;
        end
        s_valid = 1'b1; s_warp = 2'(w); s_op = op; s_addr = addr; s_pred = pred;
        if (expect_resp) begin
            e = model_op(w, op, addr, pred);
            e.acc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !s_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            total++; bad++;
            $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_warp",  m_warp,  0);
        chk("rst_m_npc",   m_npc,   0);
        chk("rst_m_mask",  m_mask,  0);
        chk("rst_m_err",   m_err,   0);
        for (int w = 0; w < NW; w++) begin
            chk("rst_tos_npc",  tos_npc[w*32 +: 32],  32'h0);
            chk("rst_tos_mask", tos_mask[w*32 +: 32], 32'hFFFF_FFFF);
        end
    endtask

    // Response acceptance: random back-pressure unless held off.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 m_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit          seen = 0, tos_pend = 0;
        int          first = 0;
        logic [1:0]  sn_warp, tw;
        logic [31:0] sn_npc, sn_mask, tn, tm;
        logic [3:0]  sn_err;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0; tos_pend = 0;
                continue;
            end
            if (tos_pend) begin
                chk("tos_npc",  tos_npc[int'(tw)*32 +: 32],  tn);
                chk("tos_mask", tos_mask[int'(tw)*32 +: 32], tm);
                tos_pend = 0;
            end
            if (m_valid) begin
                chk("s_ready_busy", s_ready, 0);
                if (!seen) begin
                    seen = 1; first = cyc;
                    sn_warp = m_warp; sn_npc = m_npc; sn_mask = m_mask; sn_err = m_err;
                end else begin
                    chk("stable_warp", m_warp, sn_warp);
                    chk("stable_npc",  m_npc,  sn_npc);
                    chk("stable_mask", m_mask, sn_mask);
                    chk("stable_err",  m_err,  sn_err);
                end
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_resp: got warp %0d npc %0h expected none", m_warp, m_npc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_warp",  m_warp, e.warp);
                        chk("m_npc",   m_npc,  e.npc);
                        chk("m_mask",  m_mask, e.mask);
                        chk("m_err",   m_err,  e.err);
                        chk("latency", first - int'(e.acc), e.lat);
                        tos_pend = 1; tw = e.warp; tn = e.npc; tm = e.mask;
                    end
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        int          w, r, v;
        logic [2:0]  op;
        logic [31:0] addr, pred;
        logic [15:0] hi16, lo16;
        rst_n = 1'b0; s_valid = 1'b0; s_warp = '0; s_op = '0; s_addr = '0; s_pred = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        // Basic PC4, then the divergence / reconvergence walk on warp 0.
        do_op(3, 3'd1, 32'h0, 32'h0, 1);
        wait_idle();
        chk("tos_npc_w3", tos_npc[3*32 +: 32], 32'h4);
        do_op(0, 3'd2, 32'h0000_0100, 32'h0, 1);
        do_op(0, 3'd3, 32'h0040_0010, 32'h0000_FFFF, 1);
        do_op(0, 3'd2, 32'h0000_0140, 32'h0, 1);
        do_op(0, 3'd2, 32'h0000_0140, 32'h0, 1);
        do_op(0, 3'd5, 32'h0, 32'h0, 1);
        // Overflow on warp 1, mask escape on warp 2, invalid codes.
        do_op(1, 3'd3, 32'h0040_0010, 32'h0000_00FF, 1);
        do_op(1, 3'd3, 32'h0040_0010, 32'h0000_000F, 1);
        do_op(1, 3'd4, 32'h0020_0000, 32'h0000_0003, 1);
        do_op(1, 3'd4, 32'h0020_0000, 32'h0000_0003, 1);
        do_op(2, 3'd3, 32'h0040_0010, 32'h0000_FFFF, 1);
        do_op(2, 3'd3, 32'h0040_0010, 32'hFFFF_0001, 1);
        do_op(2, 3'd3, 32'h0040_0010, 32'hF000_0000, 1);
        do_op(2, 3'd0, 32'h0, 32'h0, 1);
        do_op(2, 3'd7, 32'h0, 32'h0, 1);
        do_op(2, 3'd6, 32'h0000_2000, 32'h0, 1);
        wait_idle();

        // Response held off for several cycles.
        hold_ready = 1'b1;
        do_op(3, 3'd1, 32'h0, 32'h0, 1);
        repeat (8) @(negedge clk);
        hold_ready = 1'b0;
        wait_idle();

        // Randomized operation mix.
        for (int i = 0; i < 300; i++) begin
            w = $urandom_range(0, NW-1);
            r = $urandom_range(0, 15);
            v = $urandom_range(0, 16) - 8; hi16 = 16'(v * 4);
            v = $urandom_range(0, 16) - 8; lo16 = 16'(v * 4);
            addr = {hi16, lo16};
            case ($urandom_range(0, 3))
                0:       pred = 32'h0;
                1:       pred = model_top(w).mask;
                2:       pred = $urandom() & model_top(w).mask;
                default: pred = $urandom();
            endcase
            if (r < 3)       op = 3'd1;
            else if (r < 5)  begin
                op = 3'd2;
                addr = ($urandom_range(0, 1) == 1) ? model_top(w).rpc
                                                   : model_top(w).npc + 32'(4 * $urandom_range(0, 4));
            end
            else if (r < 9)  op = 3'd3;
            else if (r < 11) op = 3'd4;
            else if (r < 13) op = 3'd5;
            else if (r == 13) begin op = 3'd6; addr = 32'h1000 * $urandom_range(0, 15); end
            else if (r == 14) op = 3'd0;
            else              op = 3'd7;
            do_op(w, op, addr, pred, 1);
        end
        wait_idle();

        // Reset asserted while the request is in EXEC: no response, reset values everywhere.
        do_op(1, 3'd1, 32'h0, 32'h0, 0);
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_resp_after_rst", m_valid, 0);
        do_op(1, 3'd1, 32'h0, 32'h0, 1);
        do_op(1, 3'd5, 32'h0, 32'h0, 1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
